// File: rtl/serv_csr_pkg.sv
// Shared encodings for the SERV machine-mode CSR / interrupt slice.
package serv_csr_pkg;

  typedef enum logic [1:0] {
    CSR_SOURCE_CSR = 2'b00,
    CSR_SOURCE_EXT = 2'b01,
    CSR_SOURCE_SET = 2'b10,
    CSR_SOURCE_CLR = 2'b11
  } csr_source_e;

  localparam logic [4:0] CAUSE_MSI        = 5'd3;
  localparam logic [4:0] CAUSE_MTI        = 5'd7;
  localparam logic [4:0] CAUSE_MEI        = 5'd11;
  localparam logic [4:0] CAUSE_LOCAL_BASE = 5'd16;

  localparam logic [4:0] EXC_INSTR_MISALIGN = 5'd0;
  localparam logic [4:0] EXC_BREAKPOINT     = 5'd3;
  localparam logic [4:0] EXC_LOAD_MISALIGN  = 5'd4;
  localparam logic [4:0] EXC_STORE_MISALIGN = 5'd6;
  localparam logic [4:0] EXC_ECALL_M        = 5'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  function automatic logic [4:0] exc_code(input logic e_op, input logic ebreak,
                                          input logic mem_op, input logic mem_cmd);
    if (e_op)   return ebreak ? EXC_BREAKPOINT : EXC_ECALL_M;
    if (mem_op) return mem_cmd ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
    return EXC_INSTR_MISALIGN;
  endfunction

endpackage

// File: rtl/serv_csr_irq_arbiter.sv
// Interrupt synchronisers, fixed-priority encoder and the pending-request latch.
// Source vector order is {lirq[N-1:0], meip, mtip, msip}.
module serv_irq_arbiter
  import serv_csr_pkg::*;
#(
  parameter int  NUM_LOCAL      = 4,
  parameter int  SYNC_IRQ       = 1,
  parameter      RESET_STRATEGY = "MINI",
  localparam int LW = (NUM_LOCAL > 0) ? NUM_LOCAL : 1,
  localparam int IW = 3 + LW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [IW-1:0] irq_i,
  input  logic [IW-1:0] mask_i,
  input  logic          mie_i,
  input  logic          arb_i,
  input  logic          clr_i,
  output logic [IW-1:0] mip_o,
  output logic          new_irq_o,
  output logic [4:0]    irq_code_o
);

  localparam bit RST_EN = (RESET_STRATEGY != "NONE");

  logic [IW-1:0] mip;
  logic [IW-1:0] pend;
  logic [4:0]    code;
  logic          new_irq_q, new_irq_d;
  logic [4:0]    irq_code_q, irq_code_d;

  generate
    if (SYNC_IRQ != 0) begin : g_sync
      logic [IW-1:0] sync1_q, sync2_q;
      always_ff @(posedge clk_i) begin
        if (RST_EN && rst_i) begin
          sync1_q <= '0;
          sync2_q <= '0;
        end else begin
          sync1_q <= irq_i;
          sync2_q <= sync1_q;
        end
      end
      assign mip = sync2_q;
    end else begin : g_direct
      assign mip = irq_i;
    end
  endgenerate

  // Later assignments win: MEI > MSI > MTI > lirq[0] > ... > lirq[N-1]
  always_comb begin
    pend = mip & mask_i;
    if (NUM_LOCAL == 0) pend[3] = 1'b0;
    code = '0;
    for (int k = LW - 1; k >= 0; k--)
      if (pend[3+k]) code = CAUSE_LOCAL_BASE + 5'(k);
    if (pend[1]) code = CAUSE_MTI;
    if (pend[0]) code = CAUSE_MSI;
    if (pend[2]) code = CAUSE_MEI;
  end

  always_comb begin
    new_irq_d  = new_irq_q;
    irq_code_d = irq_code_q;
    if (clr_i) begin
      new_irq_d = 1'b0;
    end else if (arb_i && !new_irq_q && mie_i && (|pend)) begin
      new_irq_d  = 1'b1;
      irq_code_d = code;
    end
  end

  always_ff @(posedge clk_i) begin
    if (RST_EN && rst_i) begin
      new_irq_q  <= 1'b0;
      irq_code_q <= '0;
    end else begin
      new_irq_q  <= new_irq_d;
      irq_code_q <= irq_code_d;
    end
  end

  assign mip_o      = mip;
  assign new_irq_o  = new_irq_q;
  assign irq_code_o = irq_code_q;

endmodule

// File: rtl/serv_csr_irq.sv
// Bit-serial machine-mode CSR unit (mstatus/mie/mip/mcause) with multi-source interrupts.
// One CSR bit per cycle, LSB first, indexed by i_cnt.
module serv_csr_irq
  import serv_csr_pkg::*;
#(
  parameter int  NUM_LOCAL      = 4,
  parameter int  SYNC_IRQ       = 1,
  parameter      RESET_STRATEGY = "MINI",
  localparam int LW = (NUM_LOCAL > 0) ? NUM_LOCAL : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_init,
  input  logic          i_en,
  input  logic [4:0]    i_cnt,
  input  logic          i_cnt_done,
  input  logic          i_trap,
  input  logic          i_mret,
  input  logic          i_e_op,
  input  logic          i_ebreak,
  input  logic          i_mem_op,
  input  logic          i_mem_cmd,
  input  logic          i_mstatus_en,
  input  logic          i_mie_en,
  input  logic          i_mip_en,
  input  logic          i_mcause_en,
  input  logic [1:0]    i_csr_source,
  input  logic          i_csr_d_sel,
  input  logic          i_csr_imm,
  input  logic          i_rs1,
  input  logic          i_rf_csr_out,
  input  logic          i_msip,
  input  logic          i_mtip,
  input  logic          i_meip,
  input  logic [LW-1:0] i_lirq,
  output logic          o_new_irq,
  output logic          o_csr_in,
  output logic          o_q
);

  localparam bit RST_EN = (RESET_STRATEGY != "NONE");

  logic          mstatus_mie_q, mstatus_mie_d, mstatus_mpie_q, mstatus_mpie_d;
  logic          msie_q, msie_d, mtie_q, mtie_d, meie_q, meie_d;
  logic [LW-1:0] lie_q, lie_d;
  logic          mcause_int_q, mcause_int_d;
  logic [4:0]    mcause_code_q, mcause_code_d;
  logic [2+LW:0] mip;
  logic [4:0]    irq_code;
  logic          new_irq;
  logic [31:0]   mstatus_w, mie_w, mip_w, mcause_w;
  logic          csr_bit, csr_out, csr_d, csr_in;
  logic          trap_done, mret_done;

  assign trap_done = i_trap & i_cnt_done;
  assign mret_done = i_mret & i_cnt_done;

  serv_irq_arbiter #(
    .NUM_LOCAL      (NUM_LOCAL),
    .SYNC_IRQ       (SYNC_IRQ),
    .RESET_STRATEGY (RESET_STRATEGY)
  ) u_arbiter (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .irq_i      ({i_lirq, i_meip, i_mtip, i_msip}),
    .mask_i     ({lie_q, meie_q, mtie_q, msie_q}),
    .mie_i      (mstatus_mie_q),
    .arb_i      (i_cnt_done & ~i_init),
    .clr_i      (trap_done),
    .mip_o      (mip),
    .new_irq_o  (new_irq),
    .irq_code_o (irq_code)
  );

  // Parallel views of each CSR; the serial read just picks bit i_cnt.
  always_comb begin
    mstatus_w = '0;
    mstatus_w[MSTATUS_MIE]  = mstatus_mie_q;
    mstatus_w[MSTATUS_MPIE] = mstatus_mpie_q;
    mie_w = '0;
    mie_w[CAUSE_MSI] = msie_q;
    mie_w[CAUSE_MTI] = mtie_q;
    mie_w[CAUSE_MEI] = meie_q;
    mip_w = '0;
    mip_w[CAUSE_MSI] = mip[0];
    mip_w[CAUSE_MTI] = mip[1];
    mip_w[CAUSE_MEI] = mip[2];
    for (int k = 0; k < NUM_LOCAL; k++) begin
      mie_w[16+k] = lie_q[k];
      mip_w[16+k] = mip[3+k];
    end
    mcause_w = '0;
    mcause_w[4:0] = mcause_code_q;
    mcause_w[31]  = mcause_int_q;
  end

  assign csr_bit = (i_mstatus_en & mstatus_w[i_cnt]) | (i_mie_en & mie_w[i_cnt]) |
                   (i_mip_en & mip_w[i_cnt]) | (i_mcause_en & mcause_w[i_cnt]);
  assign csr_out = i_rf_csr_out | (i_en & csr_bit);
  assign csr_d   = i_csr_d_sel ? i_csr_imm : i_rs1;

  always_comb begin
    case (csr_source_e'(i_csr_source))
      CSR_SOURCE_EXT: csr_in = csr_d;
      CSR_SOURCE_SET: csr_in = csr_out | csr_d;
      CSR_SOURCE_CLR: csr_in = csr_out & ~csr_d;
      default:        csr_in = csr_out;
    endcase
  end

  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    msie_d         = msie_q;
    mtie_d         = mtie_q;
    meie_d         = meie_q;
    lie_d          = lie_q;
    mcause_int_d   = mcause_int_q;
    mcause_code_d  = mcause_code_q;
    if (i_mie_en && i_en) begin
      if (i_cnt == CAUSE_MSI) msie_d = csr_in;
      if (i_cnt == CAUSE_MTI) mtie_d = csr_in;
      if (i_cnt == CAUSE_MEI) meie_d = csr_in;
      for (int k = 0; k < NUM_LOCAL; k++)
        if (i_cnt == 5'(16 + k)) lie_d[k] = csr_in;
    end
    if (trap_done) begin
      mstatus_mie_d  = 1'b0;
      mstatus_mpie_d = mstatus_mie_q;
    end else if (mret_done) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end else if (i_mstatus_en && i_en) begin
      if (i_cnt == 5'(MSTATUS_MIE))  mstatus_mie_d  = csr_in;
      if (i_cnt == 5'(MSTATUS_MPIE)) mstatus_mpie_d = csr_in;
    end
    if (trap_done) begin
      mcause_int_d  = new_irq;
      mcause_code_d = new_irq ? irq_code : exc_code(i_e_op, i_ebreak, i_mem_op, i_mem_cmd);
    end else if (i_mcause_en && i_en) begin
      if (i_cnt < 5'd5)   mcause_code_d[i_cnt[2:0]] = csr_in;
      if (i_cnt == 5'd31) mcause_int_d = csr_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (RST_EN && i_rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      msie_q         <= 1'b0;
      mtie_q         <= 1'b0;
      meie_q         <= 1'b0;
      lie_q          <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      msie_q         <= msie_d;
      mtie_q         <= mtie_d;
      meie_q         <= meie_d;
      lie_q          <= lie_d;
    end
  end

  // mcause is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    mcause_int_q  <= mcause_int_d;
    mcause_code_q <= mcause_code_d;
  end

  assign o_new_irq = new_irq;
  assign o_csr_in  = csr_in;
  assign o_q       = csr_out;

endmodule

// File: tb/tb_serv_csr_irq.sv
// Directed bench for serv_csr_irq: serial CSR access, interrupt arbitration, traps and mret.
module tb_serv_csr_irq;
  import serv_csr_pkg::*;

  localparam logic [3:0] S_NONE = 4'b0000, S_MSTATUS = 4'b1000, S_MIE = 4'b0100;
  localparam logic [3:0] S_MIP = 4'b0010, S_MCAUSE = 4'b0001;
  localparam logic [3:0] X_NONE = 4'b0000, X_ECALL = 4'b1000, X_EBREAK = 4'b1100;
  localparam logic [3:0] X_LOAD = 4'b0010, X_STORE = 4'b0011;

  int nchk = 0;
  int nfail = 0;

  logic       i_clk, i_rst, i_init, i_en, i_cnt_done, i_trap, i_mret;
  logic [4:0] i_cnt;
  logic       i_e_op, i_ebreak, i_mem_op, i_mem_cmd;
  logic       i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en;
  logic [1:0] i_csr_source;
  logic       i_csr_d_sel, i_csr_imm, i_rs1, i_rf_csr_out;
  logic       i_msip, i_mtip, i_meip;
  logic [3:0] i_lirq;
  logic       o_new_irq, o_csr_in, o_q;
  logic [31:0] r;

  serv_csr_irq #(.NUM_LOCAL(4), .SYNC_IRQ(1), .RESET_STRATEGY("MINI")) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_init(i_init), .i_en(i_en), .i_cnt(i_cnt),
    .i_cnt_done(i_cnt_done), .i_trap(i_trap), .i_mret(i_mret), .i_e_op(i_e_op),
    .i_ebreak(i_ebreak), .i_mem_op(i_mem_op), .i_mem_cmd(i_mem_cmd),
    .i_mstatus_en(i_mstatus_en), .i_mie_en(i_mie_en), .i_mip_en(i_mip_en),
    .i_mcause_en(i_mcause_en), .i_csr_source(i_csr_source), .i_csr_d_sel(i_csr_d_sel),
    .i_csr_imm(i_csr_imm), .i_rs1(i_rs1), .i_rf_csr_out(i_rf_csr_out), .i_msip(i_msip),
    .i_mtip(i_mtip), .i_meip(i_meip), .i_lirq(i_lirq), .o_new_irq(o_new_irq),
    .o_csr_in(o_csr_in), .o_q(o_q)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    i_en = 0; i_cnt = 0; i_cnt_done = 0; i_trap = 0; i_mret = 0; i_init = 0;
    {i_e_op, i_ebreak, i_mem_op, i_mem_cmd} = 4'b0;
    {i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en} = 4'b0;
    i_csr_source = 2'b00; i_csr_d_sel = 0; i_csr_imm = 0; i_rs1 = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // One 32-cycle serial instruction; trapm gives i_trap per bit, rd collects o_q.
  task automatic instr(input logic [3:0] sel, input logic [1:0] src, input logic dsel,
                       input logic [31:0] wd, input logic [31:0] trapm, input logic mret,
                       input logic [3:0] exc, output logic [31:0] rd);
    rd = '0;
    {i_mstatus_en, i_mie_en, i_mip_en, i_mcause_en} = sel;
    i_csr_source = src; i_csr_d_sel = dsel; i_mret = mret;
    {i_e_op, i_ebreak, i_mem_op, i_mem_cmd} = exc;
    for (int c = 0; c < 32; c++) begin
      i_en = 1; i_cnt = 5'(c); i_cnt_done = (c == 31); i_trap = trapm[c];
      i_csr_imm = dsel ? wd[c] : ~wd[c];
      i_rs1     = dsel ? ~wd[c] : wd[c];
      @(negedge i_clk);
      rd[c] = o_q;
      @(posedge i_clk);
      #1;
    end
    idle_inputs();
  endtask

  task automatic rd_csr(input logic [3:0] sel, output logic [31:0] rd);
    instr(sel, CSR_SOURCE_CSR, 1'b0, 32'h0, 32'h0, 1'b0, X_NONE, rd);
  endtask

  task automatic wr_csr(input logic [3:0] sel, input logic [1:0] src, input logic dsel,
                        input logic [31:0] wd);
    logic [31:0] dummy;
    instr(sel, src, dsel, wd, 32'h0, 1'b0, X_NONE, dummy);
  endtask

  task automatic take_trap(input logic [3:0] exc);
    logic [31:0] dummy;
    instr(S_NONE, CSR_SOURCE_CSR, 1'b0, 32'h0, 32'h8000_0000, 1'b0, exc, dummy);
  endtask

  task automatic do_mret();
    logic [31:0] dummy;
    instr(S_NONE, CSR_SOURCE_CSR, 1'b0, 32'h0, 32'h0, 1'b1, X_NONE, dummy);
  endtask

  task automatic pulse_done(input logic init);
    i_cnt_done = 1; i_init = init;
    tick(1);
    i_cnt_done = 0; i_init = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rf_csr_out = 0; i_msip = 0; i_mtip = 0; i_meip = 0; i_lirq = 4'b0;
    i_rst = 1;
    tick(2);
    i_rst = 0;
    nchk++; if (o_new_irq !== 1'b0) begin nfail++; $display("FAIL reset_new_irq got %b want 0", o_new_irq); end
    rd_csr(S_MIE, r);
    nchk++; if (r !== 32'h0) begin nfail++; $display("FAIL reset_mie got %h want 00000000", r); end
    rd_csr(S_MSTATUS, r);
    nchk++; if (r !== 32'h0) begin nfail++; $display("FAIL reset_mstatus got %h want 00000000", r); end
    rd_csr(S_MIP, r);
    nchk++; if (r !== 32'h0) begin nfail++; $display("FAIL reset_mip got %h want 00000000", r); end
  endtask

  task automatic test_mie_mip();
    wr_csr(S_MIE, CSR_SOURCE_EXT, 1'b0, 32'h0000_0880);
    rd_csr(S_MIE, r);
    nchk++; if (r !== 32'h0000_0880) begin nfail++; $display("FAIL mie_ext got %h want 00000880", r); end
    wr_csr(S_MIE, CSR_SOURCE_SET, 1'b1, 32'h0000_0008);
    rd_csr(S_MIE, r);
    nchk++; if (r !== 32'h0000_0888) begin nfail++; $display("FAIL mie_set_imm got %h want 00000888", r); end
    wr_csr(S_MIE, CSR_SOURCE_CLR, 1'b0, 32'h0000_0800);
    rd_csr(S_MIE, r);
    nchk++; if (r !== 32'h0000_0088) begin nfail++; $display("FAIL mie_clr got %h want 00000088", r); end
    wr_csr(S_MIE, CSR_SOURCE_EXT, 1'b0, 32'hFFFF_FFFF);
    rd_csr(S_MIE, r);
    nchk++; if (r !== 32'h000F_0888) begin nfail++; $display("FAIL mie_all_ones got %h want 000f0888", r); end
    i_mtip = 1;
    tick(3);
    rd_csr(S_MIP, r);
    nchk++; if (r !== 32'h0000_0080) begin nfail++; $display("FAIL mip_mtip got %h want 00000080", r); end
    wr_csr(S_MIP, CSR_SOURCE_EXT, 1'b0, 32'hFFFF_FFFF);
    rd_csr(S_MIP, r);
    nchk++; if (r !== 32'h0000_0080) begin nfail++; $display("FAIL mip_readonly got %h want 00000080", r); end
    i_lirq = 4'b0010;
    tick(3);
    rd_csr(S_MIP, r);
    nchk++; if (r !== 32'h0002_0080) begin nfail++; $display("FAIL mip_lirq1 got %h want 00020080", r); end
    i_mtip = 0; i_lirq = 4'b0;
    tick(3);
    rd_csr(S_MIP, r);
    nchk++; if (r !== 32'h0) begin nfail++; $display("FAIL mip_clear got %h want 00000000", r); end
    nchk++; if (o_new_irq !== 1'b0) begin nfail++; $display("FAIL mie_gated_no_irq got %b want 0", o_new_irq); end
  endtask

  task automatic test_timer_irq();
    wr_csr(S_MIE, CSR_SOURCE_EXT, 1'b0, 32'h0000_0080);
    wr_csr(S_MSTATUS, CSR_SOURCE_EXT, 1'b0, 32'h0000_0008);
    rd_csr(S_MSTATUS, r);
    nchk++; if (r !== 32'h0000_0008) begin nfail++; $display("FAIL mstatus_mie_set got %h want 00000008", r); end
    i_mtip = 1;
    pulse_done(1'b0);
    nchk++; if (o_new_irq !== 1'b0) begin nfail++; $display("FAIL sync_edge1 got %b want 0", o_new_irq); end
    pulse_done(1'b0);
    nchk++; if (o_new_irq !== 1'b0) begin nfail++; $display("FAIL sync_edge2 got %b want 0", o_new_irq); end
    pulse_done(1'b1);
    nchk++; if (o_new_irq !== 1'b0) begin nfail++; $display("FAIL init_suppress got %b want 0", o_new_irq); end
    pulse_done(1'b0);
    nchk++; if (o_new_irq !== 1'b1) begin nfail++; $display("FAIL timer_raise got %b want 1", o_new_irq); end
    take_trap(X_NONE);
    nchk++; if (o_new_irq !== 1'b0) begin nfail++; $display("FAIL trap_clears_irq got %b want 0", o_new_irq); end
    rd_csr(S_MCAUSE, r);
    nchk++; if (r !== 32'h8000_0007) begin nfail++; $display("FAIL mcause_mti got %h want 80000007", r); end
    rd_csr(S_MSTATUS, r);
    nchk++; if (r !== 32'h0000_0080) begin nfail++; $display("FAIL mstatus_after_trap got %h want 00000080", r); end
    i_mtip = 0;
    tick(3);
  endtask

  task automatic test_priority();
    wr_csr(S_MIE, CSR_SOURCE_EXT, 1'b0, 32'h0001_0888);
    i_meip = 1; i_msip = 1; i_lirq = 4'b0001;
    tick(3);
    wr_csr(S_MSTATUS, CSR_SOURCE_EXT, 1'b0, 32'h0000_0008);
    nchk++; if (o_new_irq !== 1'b1) begin nfail++; $display("FAIL prio_raise got %b want 1", o_new_irq); end
    take_trap(X_NONE);
    rd_csr(S_MCAUSE, r);
    nchk++; if (r !== 32'h8000_000B) begin nfail++; $display("FAIL prio_mei got %h want 8000000b", r); end
    i_meip = 0;
    tick(3);
    do_mret();
    nchk++; if (o_new_irq !== 1'b0) begin nfail++; $display("FAIL no_raise_at_mret got %b want 0", o_new_irq); end
    rd_csr(S_MCAUSE, r);
    nchk++; if (o_new_irq !== 1'b1) begin nfail++; $display("FAIL msi_reraise got %b want 1", o_new_irq); end
    take_trap(X_NONE);
    rd_csr(S_MCAUSE, r);
    nchk++; if (r !== 32'h8000_0003) begin nfail++; $display("FAIL prio_msi got %h want 80000003", r); end
    i_msip = 0;
    tick(3);
    do_mret();
    rd_csr(S_MSTATUS, r);
    nchk++; if (r !== 32'h0000_0088) begin nfail++; $display("FAIL mstatus_after_mret got %h want 00000088", r); end
    take_trap(X_NONE);
    rd_csr(S_MCAUSE, r);
    nchk++; if (r !== 32'h8000_0010) begin nfail++; $display("FAIL prio_lirq0 got %h want 80000010", r); end
    i_lirq = 4'b0;
    tick(3);
  endtask

  task automatic test_mret_rearm();
    i_mtip = 1;
    tick(3);
    do_mret();
    nchk++; if (o_new_irq !== 1'b0) begin nfail++; $display("FAIL rearm_at_mret got %b want 0", o_new_irq); end
    rd_csr(S_MSTATUS, r);
    nchk++; if (o_new_irq !== 1'b1) begin nfail++; $display("FAIL rearm_next got %b want 1", o_new_irq); end
    rd_csr(S_MSTATUS, r);
    nchk++; if (o_new_irq !== 1'b1) begin nfail++; $display("FAIL rearm_hold got %b want 1", o_new_irq); end
    take_trap(X_NONE);
    nchk++; if (o_new_irq !== 1'b0) begin nfail++; $display("FAIL rearm_trap_clear got %b want 0", o_new_irq); end
    rd_csr(S_MCAUSE, r);
    nchk++; if (r !== 32'h8000_0007) begin nfail++; $display("FAIL rearm_mcause got %h want 80000007", r); end
    nchk++; if (o_new_irq !== 1'b0) begin nfail++; $display("FAIL rearm_no_dup got %b want 0", o_new_irq); end
    i_mtip = 0;
    tick(3);
  endtask

  task automatic test_exceptions();
    take_trap(X_ECALL);
    rd_csr(S_MCAUSE, r);
    nchk++; if (r !== 32'h0000_000B) begin nfail++; $display("FAIL exc_ecall got %h want 0000000b", r); end
    take_trap(X_EBREAK);
    rd_csr(S_MCAUSE, r);
    nchk++; if (r !== 32'h0000_0003) begin nfail++; $display("FAIL exc_ebreak got %h want 00000003", r); end
    take_trap(X_LOAD);
    rd_csr(S_MCAUSE, r);
    nchk++; if (r !== 32'h0000_0004) begin nfail++; $display("FAIL exc_load got %h want 00000004", r); end
    take_trap(X_STORE);
    rd_csr(S_MCAUSE, r);
    nchk++; if (r !== 32'h0000_0006) begin nfail++; $display("FAIL exc_store got %h want 00000006", r); end
    take_trap(X_NONE);
    rd_csr(S_MCAUSE, r);
    nchk++; if (r !== 32'h0000_0000) begin nfail++; $display("FAIL exc_jump got %h want 00000000", r); end
  endtask

  task automatic test_mcause_write();
    wr_csr(S_MCAUSE, CSR_SOURCE_EXT, 1'b0, 32'hFFFF_FFFF);
    rd_csr(S_MCAUSE, r);
    nchk++; if (r !== 32'h8000_001F) begin nfail++; $display("FAIL mcause_wr_ones got %h want 8000001f", r); end
    wr_csr(S_MCAUSE, CSR_SOURCE_EXT, 1'b1, 32'h1234_5675);
    rd_csr(S_MCAUSE, r);
    nchk++; if (r !== 32'h0000_0015) begin nfail++; $display("FAIL mcause_wr_imm got %h want 00000015", r); end
  endtask

  task automatic test_trap_mid_mret();
    wr_csr(S_MSTATUS, CSR_SOURCE_EXT, 1'b0, 32'h0000_0080);
    instr(S_MSTATUS, CSR_SOURCE_CSR, 1'b0, 32'h0, 32'h0000_0006, 1'b1, X_NONE, r);
    nchk++; if (r !== 32'h0000_0080) begin nfail++; $display("FAIL mid_mret_mstatus got %h want 00000080", r); end
    rd_csr(S_MSTATUS, r);
    nchk++; if (r !== 32'h0000_0088) begin nfail++; $display("FAIL post_mret_mstatus got %h want 00000088", r); end
    rd_csr(S_MCAUSE, r);
    nchk++; if (r !== 32'h0000_0015) begin nfail++; $display("FAIL mid_trap_mcause got %h want 00000015", r); end
  endtask

  task automatic test_reset_midway();
    i_mtip = 1;
    tick(3);
    rd_csr(S_MSTATUS, r);
    nchk++; if (o_new_irq !== 1'b1) begin nfail++; $display("FAIL pre_reset_irq got %b want 1", o_new_irq); end
    i_en = 1; i_cnt = 5'd5; i_rst = 1;
    tick(1);
    i_rst = 0; i_en = 0; i_cnt = 0;
    nchk++; if (o_new_irq !== 1'b0) begin nfail++; $display("FAIL reset_abort_irq got %b want 0", o_new_irq); end
    i_mtip = 0;
    rd_csr(S_MIE, r);
    nchk++; if (r !== 32'h0) begin nfail++; $display("FAIL reset_mid_mie got %h want 00000000", r); end
    rd_csr(S_MSTATUS, r);
    nchk++; if (r !== 32'h0) begin nfail++; $display("FAIL reset_mid_mstatus got %h want 00000000", r); end
    nchk++; if (o_new_irq !== 1'b0) begin nfail++; $display("FAIL reset_mid_no_irq got %b want 0", o_new_irq); end
  endtask

  initial begin
    test_reset();
    test_mie_mip();
    test_timer_irq();
    test_priority();
    test_mret_rearm();
    test_exceptions();
    test_mcause_write();
    test_trap_mid_mret();
    test_reset_midway();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
